// File: rtl/mem_arbiter.sv
// Two-master arbiter (IFU fetch, LSU load/store) for a single memory port.
// Fixed LSU priority with a starvation guard, one transaction in flight at a time.
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_resp_valid,
    input  logic          ifu_resp_ready,
    output logic [DW-1:0] ifu_rdata,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic [AW-1:0] lsu_addr,
    input  logic          lsu_wen,
    input  logic [DW-1:0] lsu_wdata,
    input  logic [7:0]    lsu_wmask,
    output logic          lsu_resp_valid,
    input  logic          lsu_resp_ready,
    output logic [DW-1:0] lsu_rdata,

    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic [7:0]    mem_wmask,
    input  logic          mem_resp_valid,
    output logic          mem_resp_ready,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t        state;
    logic [3:0]    starve_cnt;
    logic [DW-1:0] rdata_q;
    logic          grant_ifu;
    logic          grant_lsu;
    logic          owner_resp_ready;

    // NOTE: every variable gets a default before the if-chain so no latch is inferred.
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (state == IDLE) begin
            if (starve_cnt == LIMIT && ifu_req_valid) grant_ifu = 1'b1;
            else if (lsu_req_valid)                   grant_lsu = 1'b1;
            else if (ifu_req_valid)                   grant_ifu = 1'b1;
        end
    end

    assign ifu_req_ready    = grant_ifu;
    assign lsu_req_ready    = grant_lsu;
    assign owner_resp_ready = owner ? lsu_resp_ready : ifu_resp_ready;
    assign ifu_rdata        = rdata_q;
    assign lsu_rdata        = rdata_q;

    // NOTE: all state, including the datapath latches, uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= 1'b0;
            starve_cnt     <= '0;
            busy           <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_resp_ready <= 1'b0;
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;
            mem_addr       <= '0;
            mem_wen        <= 1'b0;
            mem_wdata      <= '0;
            mem_wmask      <= '0;
            rdata_q        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        owner     <= 1'b1;
                        mem_addr  <= lsu_addr;
                        mem_wen   <= lsu_wen;
                        mem_wdata <= lsu_wdata;
                        mem_wmask <= lsu_wmask;
                        // Count only LSU wins that actually made a waiting IFU wait.
                        if (!ifu_req_valid)           starve_cnt <= '0;
                        else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
                    end else if (grant_ifu) begin
                        owner      <= 1'b0;
                        mem_addr   <= ifu_addr;
                        mem_wen    <= 1'b0;
                        mem_wdata  <= '0;
                        mem_wmask  <= '0;
                        starve_cnt <= '0;
                    end
                    if (grant_lsu || grant_ifu) begin
                        state         <= REQ;
                        busy          <= 1'b1;
                        mem_req_valid <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state          <= WAIT;
                        mem_req_valid  <= 1'b0;
                        mem_resp_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state          <= RESP;
                        mem_resp_ready <= 1'b0;
                        rdata_q        <= mem_wen ? '0 : mem_rdata;
                        ifu_resp_valid <= !owner;
                        lsu_resp_valid <= owner;
                    end
                end
                RESP: begin
                    if (owner_resp_ready) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        ifu_resp_valid <= 1'b0;
                        lsu_resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// compared each cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]    lsu_wmask;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [7:0]    mem_wmask;
    logic          busy, owner;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    req_t ifu_pend, lsu_pend, txn;
    int   ifu_p, lsu_p, mrdy_p, mresp_p, irr_p, lrr_p;
    int   mrdy_hold, irr_hold;
    logic rst_req;
    bit   have_txn, sent, got, txn_lsu, s_rv;
    int   m_starve;
    logic [31:0] exp_rdata;
    int   g_ifu_cyc, r_ifu_cyc, mreq_cyc;
    bit   grants[$];   // 1 = LSU grant, 0 = IFU grant

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.v     = 1'b1;
        r.addr  = $urandom;
        r.wen   = 1'($urandom_range(1));
        r.wdata = $urandom;
        r.wmask = 8'($urandom);
        return r;
    endfunction

    function automatic logic [31:0] grant_vec();
        logic [31:0] v = '0;
        foreach (grants[i]) if (i < 32) v[i] = grants[i];
        return v;
    endfunction

    task automatic model_reset();
        have_txn = 0; sent = 0; got = 0; s_rv = 0;
        m_starve = 0; mrdy_hold = 0; irr_hold = 0;
    endtask

    // One clock: drive at the falling edge, check 1ns later, advance the model.
    task automatic step();
        bit exp_ifu_rdy, exp_lsu_rdy;
        @(negedge clk);
        cyc++;
        rst = rst_req;
        if (!ifu_pend.v && $urandom_range(99) < ifu_p) ifu_pend = rand_req();
        if (!lsu_pend.v && $urandom_range(99) < lsu_p) lsu_pend = rand_req();
        ifu_req_valid  = ifu_pend.v;
        ifu_addr       = ifu_pend.addr;
        lsu_req_valid  = lsu_pend.v;
        lsu_addr       = lsu_pend.addr;
        lsu_wen        = lsu_pend.wen;
        lsu_wdata      = lsu_pend.wdata;
        lsu_wmask      = lsu_pend.wmask;
        ifu_resp_ready = (irr_hold == 0) && ($urandom_range(99) < irr_p);
        lsu_resp_ready = $urandom_range(99) < lrr_p;
        mem_req_ready  = (mrdy_hold == 0) && ($urandom_range(99) < mrdy_p);
        if (!s_rv && have_txn && sent && !got) s_rv = $urandom_range(99) < mresp_p;
        mem_resp_valid = s_rv;
        mem_rdata      = mem_fn(txn.addr);
        #1;

        if (rst) begin
            model_reset();
            return;
        end

        exp_ifu_rdy = 0;
        exp_lsu_rdy = 0;
        if (!have_txn) begin
            if (m_starve == LIMIT && ifu_req_valid) exp_ifu_rdy = 1;
            else if (lsu_req_valid)                 exp_lsu_rdy = 1;
            else if (ifu_req_valid)                 exp_ifu_rdy = 1;
        end

        check("ifu_req_ready", ifu_req_ready, exp_ifu_rdy);
        check("lsu_req_ready", lsu_req_ready, exp_lsu_rdy);
        check("busy", busy, have_txn);
        check("starve_cnt", dut.starve_cnt, m_starve);
        check("mem_req_valid", mem_req_valid, have_txn && !sent);
        check("mem_resp_ready", mem_resp_ready, have_txn && sent && !got);
        check("ifu_resp_valid", ifu_resp_valid, got && !txn_lsu);
        check("lsu_resp_valid", lsu_resp_valid, got && txn_lsu);
        if (have_txn) begin
            check("owner", owner, txn_lsu);
            check("mem_fields", {mem_addr, mem_wen, mem_wmask}, {txn.addr, txn.wen, txn.wmask});
            if (txn_lsu) check("mem_wdata", mem_wdata, txn.wdata);
        end
        if (got) check("resp_rdata", txn_lsu ? lsu_rdata : ifu_rdata, exp_rdata);
        if (mem_resp_valid) check("mem_resp_only_in_wait", mem_resp_ready, 1'b1);

        if (ifu_req_ready) g_ifu_cyc = cyc;
        if (mem_req_valid && mreq_cyc < 0) mreq_cyc = cyc;
        if (ifu_resp_valid && r_ifu_cyc < 0) r_ifu_cyc = cyc;

        if (exp_ifu_rdy || exp_lsu_rdy) begin
            txn_lsu = exp_lsu_rdy;
            txn     = exp_lsu_rdy ? lsu_pend : ifu_pend;
            if (exp_lsu_rdy) begin
                lsu_pend.v = 0;
                if (!ifu_req_valid)      m_starve = 0;
                else if (m_starve < LIMIT) m_starve++;
            end else begin
                ifu_pend.v = 0;
                txn.wen    = 0;
                txn.wmask  = 0;
                m_starve   = 0;
            end
            grants.push_back(exp_lsu_rdy);
            have_txn = 1; sent = 0; got = 0;
        end else if (have_txn && !sent) begin
            if (mrdy_hold > 0) mrdy_hold--;
            if (mem_req_ready) sent = 1;
        end else if (have_txn && !got) begin
            if (s_rv) begin
                got       = 1;
                s_rv      = 0;
                exp_rdata = txn.wen ? 32'h0 : mem_fn(txn.addr);
            end
        end else if (got) begin
            if (irr_hold > 0 && !txn_lsu) irr_hold--;
            if (txn_lsu ? lsu_resp_ready : ifu_resp_ready) begin
                have_txn = 0;
                got      = 0;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((have_txn || ifu_pend.v || lsu_pend.v) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", {have_txn, ifu_pend.v, lsu_pend.v}, 3'b000);
    endtask

    task automatic set_knobs(input int ip, input int lp, input int mr, input int ms,
                             input int ir, input int lr);
        ifu_p = ip; lsu_p = lp; mrdy_p = mr; mresp_p = ms; irr_p = ir; lrr_p = lr;
    endtask

    task automatic check_quiet_outputs(input string tag);
        check(tag, {busy, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid,
                    ifu_req_ready, lsu_req_ready}, 7'b0);
    endtask

    initial begin
        int k;
        logic [31:0] gv;
        ifu_pend = '0; lsu_pend = '0; txn = '0;
        set_knobs(0, 0, 100, 100, 100, 100);
        model_reset();
        rst_req = 1'b1;
        g_ifu_cyc = -1; r_ifu_cyc = -1; mreq_cyc = -1;

        // Reset state
        step();
        step();
        rst_req = 1'b0;
        @(posedge clk);
        #1;
        check_quiet_outputs("reset_outputs");
        check("reset_owner", owner, 1'b0);
        check("reset_latches", {mem_addr, mem_wen, mem_wdata, mem_wmask}, 73'b0);
        check("reset_starve", dut.starve_cnt, 4'd0);

        // Single zero-wait IFU fetch
        ifu_pend = '{v: 1'b1, addr: 32'h8000_0000, wen: 1'b0, wdata: 32'h0, wmask: 8'h0};
        drain(20);
        check("fetch_mreq_latency", mreq_cyc - g_ifu_cyc, 1);
        check("fetch_resp_latency", r_ifu_cyc - g_ifu_cyc, 3);

        // LSU store: latched wen/mask visible on the memory port in the REQ cycle
        lsu_pend = '{v: 1'b1, addr: 32'h8000_1000, wen: 1'b1, wdata: 32'hDEAD_BEEF, wmask: 8'h0F};
        step();
        step();
        check("store_port", {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask},
              {1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F});
        drain(20);

        // Simultaneous requests: LSU first, IFU right after
        grants.delete();
        ifu_pend = rand_req();
        lsu_pend = rand_req();
        drain(40);
        check("simul_order", {grant_vec(), 32'(grants.size())}, {32'h1, 32'd2});

        // Backpressure on memory request and IFU response while LSU waits
        ifu_pend  = rand_req();
        mrdy_hold = 3;
        irr_hold  = 2;
        step();
        lsu_pend = rand_req();
        drain(40);
        check("bp_holds_spent", {mrdy_hold[3:0], irr_hold[3:0]}, 8'h00);

        // Starvation guard with both masters continuously requesting
        grants.delete();
        set_knobs(100, 100, 100, 100, 100, 100);
        for (int n = 0; n < 400 && grants.size() < 22; n++) step();
        k = -1;
        foreach (grants[i]) if (k < 0 && !grants[i]) k = i;
        gv = '0;
        if (k >= 0 && grants.size() >= k + 11)
            for (int i = 0; i < 10; i++) gv[i] = grants[k + 1 + i];
        check("starve_sequence", gv[9:0], 10'b0111101111);
        set_knobs(0, 0, 100, 100, 100, 100);
        drain(40);

        // Reset while waiting for memory, then a fresh LSU request
        mresp_p  = 0;
        lsu_pend = rand_req();
        for (int n = 0; n < 20 && !(have_txn && sent); n++) step();
        check("reached_wait", {have_txn, sent}, 2'b11);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        @(posedge clk);
        #1;
        check_quiet_outputs("mid_reset_outputs");
        mresp_p  = 100;
        grants.delete();
        lsu_pend = rand_req();
        drain(20);
        check("post_reset_grant", {grant_vec(), 32'(grants.size())}, {32'h1, 32'd1});

        // Randomized traffic
        set_knobs(30, 40, 60, 50, 70, 70);
        for (int n = 0; n < 3000; n++) step();
        set_knobs(0, 0, 100, 100, 100, 100);
        drain(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
